rcmd_channel: RTL and testbench

//   AXI read-address sequencer for the per-frame encode read stream. On start_pulse it

---
 rtl/rcmd_channel.sv | 148 ++++++++++++++
 tb/tb_rcmd_channel.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcmd_channel.sv
// AXI read-address sequencer for the per-frame encode read stream: one parameter-block
// read, then one 3-beat burst per macroblock, with outstanding bursts limited by credits.
module rcmd_channel #(
   parameter int ID_WIDTH   = 2,
   parameter int ADDR_WIDTH = 64,
   parameter int MB_STRIDE  = 384,
   parameter int MAX_OUT    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_pulse,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [15:0]           mb_total,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic                  m_axi_rvalid,
   input  logic                  m_axi_rready,
   input  logic                  m_axi_rlast,
   output logic                  busy,
   output logic                  done,
   output logic [3:0]            outstanding
);

   typedef enum logic [2:0] {S_IDLE, S_PARAM, S_MB, S_DRAIN, S_DONE} state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] araddr_nx;
   logic [7:0]            arlen_nx;
   logic                  arvalid_nx, busy_nx, done_nx;
   logic [15:0]           mb_total_q, mb_total_nx, mb_issued, mb_issued_nx;
   logic [3:0]            outstanding_nx;
   logic                  ar_hs, rl_hs, credit_ok;

   // Credit counter update; a concurrent issue and retire cancel out.
   function automatic logic [3:0] credit_next(input logic [3:0] cur, input logic inc,
                                              input logic dec);
      case ({inc, dec})
         2'b10:   credit_next = cur + 4'd1;
         2'b01:   credit_next = cur - 4'd1;
         default: credit_next = cur;
      endcase
   endfunction

   assign m_axi_arsize  = 3'd7;
   assign m_axi_arburst = 2'b01;
   assign m_axi_arid    = '0;

   assign ar_hs          = m_axi_arvalid & m_axi_arready;
   // Stray rlast with nothing outstanding must not underflow the credit count.
   assign rl_hs          = m_axi_rvalid & m_axi_rready & m_axi_rlast & (outstanding != 4'd0);
   assign outstanding_nx = credit_next(outstanding, ar_hs, rl_hs);
   assign credit_ok      = outstanding_nx < 4'(MAX_OUT);

   always_comb begin
      state_nx     = state;
      araddr_nx    = m_axi_araddr;
      arlen_nx     = m_axi_arlen;
      arvalid_nx   = m_axi_arvalid;
      busy_nx      = busy;
      done_nx      = 1'b0;
      mb_total_nx  = mb_total_q;
      mb_issued_nx = mb_issued;
      case (state)
         S_IDLE: begin
            if (start_pulse) begin
               state_nx     = S_PARAM;
               araddr_nx    = base_addr;
               arlen_nx     = 8'd0;
               arvalid_nx   = 1'b1;
               busy_nx      = 1'b1;
               mb_total_nx  = mb_total;
               mb_issued_nx = 16'd0;
            end
         end
         S_PARAM: begin
            if (ar_hs) begin
               if (mb_total_q == 16'd0) begin
                  state_nx   = S_DRAIN;
                  arvalid_nx = 1'b0;
               end else begin
                  state_nx   = S_MB;
                  araddr_nx  = m_axi_araddr + ADDR_WIDTH'(128);
                  arlen_nx   = 8'd2;
                  arvalid_nx = credit_ok;
               end
            end
         end
         S_MB: begin
            // arvalid is looked ahead from next-cycle credits, so it never drops un-accepted.
            if (ar_hs) begin
               mb_issued_nx = mb_issued + 16'd1;
               araddr_nx    = m_axi_araddr + ADDR_WIDTH'(MB_STRIDE);
               if (mb_issued == mb_total_q - 16'd1) begin
                  state_nx   = S_DRAIN;
                  arvalid_nx = 1'b0;
               end else begin
                  arvalid_nx = credit_ok;
               end
            end else if (!m_axi_arvalid) begin
               arvalid_nx = credit_ok;
            end
         end
         S_DRAIN: begin
            if (outstanding == 4'd0) begin
               state_nx = S_DONE;
               done_nx  = 1'b1;
               busy_nx  = 1'b0;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arlen   <= 8'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         outstanding   <= 4'd0;
         mb_issued     <= 16'd0;
         mb_total_q    <= 16'd0;
      end else begin
         state         <= state_nx;
         m_axi_arvalid <= arvalid_nx;
         m_axi_araddr  <= araddr_nx;
         m_axi_arlen   <= arlen_nx;
         busy          <= busy_nx;
         done          <= done_nx;
         outstanding   <= outstanding_nx;
         mb_issued     <= mb_issued_nx;
         mb_total_q    <= mb_total_nx;
      end
   end

endmodule

// File: tb/tb_rcmd_channel.sv
// Randomized bench for rcmd_channel: a frame-level model predicts every AR, the credit
// count and the done pulse; a negedge monitor pops and compares against the DUT.
module tb_rcmd_channel;

   localparam int AW     = 64;
   localparam int IDW    = 2;
   localparam int STRIDE = 384;
   localparam int MAXO   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_pulse;
   logic [AW-1:0] base_addr;
   logic [15:0]   mb_total;
   logic [AW-1:0] m_axi_araddr;
   logic [7:0]    m_axi_arlen;
   logic [2:0]    m_axi_arsize;
   logic [1:0]    m_axi_arburst;
   logic [IDW-1:0] m_axi_arid;
   logic          m_axi_arvalid;
   logic          m_axi_arready;
   logic          m_axi_rvalid;
   logic          m_axi_rready;
   logic          m_axi_rlast;
   logic          busy;
   logic          done;
   logic [3:0]    outstanding;

   always #5 clk = ~clk;

   rcmd_channel #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .MB_STRIDE(STRIDE), .MAX_OUT(MAXO)) dut (
      .clk(clk), .rst(rst), .start_pulse(start_pulse), .base_addr(base_addr),
      .mb_total(mb_total), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arid(m_axi_arid),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rlast(m_axi_rlast),
      .busy(busy), .done(done), .outstanding(outstanding)
   );

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave knobs (written by the main sequence only)
   int ar_pct = 100, rv_pct = 100, rr_pct = 100;
   int r_limit = -1;
   int stray_id = 0;
   int stray_done = 0;

   // Model / scoreboard state (written by the monitor only)
   logic [63:0] exp_ar_addr[$];
   logic [7:0]  exp_ar_len[$];
   int          exp_done[$];
   int          sq[$];
   int          cyc = 0;
   int          model_out = 0;
   int          ar_total = 0;
   int          beat_total = 0;
   int          start_cyc = -10;
   bit          model_active = 1'b0;
   bit          model_busy = 1'b0;
   bit          rst_prev = 1'b0;
   bit          stall_prev = 1'b0;
   logic [63:0] prev_addr, start_base;
   logic [7:0]  prev_len;

   // Read slave: accepts addresses randomly and returns the beats of accepted bursts in order.
   initial begin
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rready  = 1'b0;
      m_axi_rlast   = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         m_axi_arready = ($urandom_range(99) < ar_pct);
         m_axi_rready  = ($urandom_range(99) < rr_pct);
         if (stray_id != stray_done) begin
            stray_done   = stray_id;
            m_axi_rvalid = 1'b1;
            m_axi_rready = 1'b1;
            m_axi_rlast  = 1'b1;
         end else if (sq.size() > 0 && (r_limit < 0 || beat_total < r_limit) &&
                      $urandom_range(99) < rv_pct) begin
            m_axi_rvalid = 1'b1;
            m_axi_rlast  = (sq[0] == 1);
         end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'($urandom_range(1));
         end
      end
   end

   // Monitor and reference model
   initial begin
      bit was_active, ar_hs, dec, accepted;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_prev) begin
            chk("rst_arvalid", m_axi_arvalid, 0);
            chk("rst_araddr", m_axi_araddr, 0);
            chk("rst_arlen", m_axi_arlen, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_outstanding", outstanding, 0);
         end
         if (rst) begin
            exp_ar_addr.delete();
            exp_ar_len.delete();
            exp_done.delete();
            sq.delete();
            model_out    = 0;
            model_active = 1'b0;
            model_busy   = 1'b0;
            stall_prev   = 1'b0;
            start_cyc    = -10;
            rst_prev     = 1'b1;
         end else begin
            rst_prev   = 1'b0;
            was_active = model_active;
            chk("outstanding", outstanding, 64'(model_out));
            chk("busy", busy, model_busy);
            if (stall_prev) begin
               chk("stall_arvalid", m_axi_arvalid, 1);
               chk("stall_araddr", m_axi_araddr, prev_addr);
               chk("stall_arlen", m_axi_arlen, prev_len);
            end
            if (cyc == start_cyc + 1) begin
               chk("start_arvalid", m_axi_arvalid, 1);
               chk("start_araddr", m_axi_araddr, start_base);
            end
            if (exp_done.size() > 0 && exp_done[0] == cyc) begin
               chk("done_pulse", done, 1);
               void'(exp_done.pop_front());
               model_active = 1'b0;
            end else begin
               chk("done_quiet", done, 0);
            end
            ar_hs = m_axi_arvalid && m_axi_arready;
            if (ar_hs) begin
               ar_total++;
               if (exp_ar_addr.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL ar_unexpected: got AR at 0x%0h, expected none", m_axi_araddr);
               end else begin
                  chk("ar_addr", m_axi_araddr, exp_ar_addr.pop_front());
                  chk("ar_len", m_axi_arlen, exp_ar_len.pop_front());
                  chk("ar_size", m_axi_arsize, 3'd7);
                  chk("ar_burst", m_axi_arburst, 2'b01);
                  chk("ar_id", m_axi_arid, 0);
               end
               sq.push_back(int'(m_axi_arlen) + 1);
            end
            stall_prev = m_axi_arvalid && !m_axi_arready;
            prev_addr  = m_axi_araddr;
            prev_len   = m_axi_arlen;
            if (m_axi_rvalid && m_axi_rready) begin
               beat_total++;
               if (sq.size() > 0) begin
                  sq[0] = sq[0] - 1;
                  if (sq[0] == 0) void'(sq.pop_front());
               end
            end
            dec = m_axi_rvalid && m_axi_rready && m_axi_rlast && (model_out > 0);
            model_out = model_out + int'(ar_hs) - int'(dec);
            if (dec && model_out == 0 && model_active && exp_ar_addr.size() == 0)
               exp_done.push_back(cyc + 2);
            accepted = start_pulse && !was_active;
            if (accepted) begin
               model_active = 1'b1;
               start_cyc    = cyc;
               start_base   = base_addr;
               exp_ar_addr.push_back(base_addr);
               exp_ar_len.push_back(8'd0);
               for (int i = 0; i < int'(mb_total); i++) begin
                  exp_ar_addr.push_back(base_addr + 64'd128 + 64'(STRIDE) * 64'(i));
                  exp_ar_len.push_back(8'd2);
               end
               model_busy = 1'b1;
            end else if (exp_done.size() > 0 && exp_done[0] == cyc + 1) begin
               model_busy = 1'b0;
            end
         end
      end
   end

   task automatic start_frame(input logic [63:0] b, input logic [15:0] n);
      @(posedge clk);
      #1;
      base_addr   = b;
      mb_total    = n;
      start_pulse = 1'b1;
      @(posedge clk);
      #1;
      start_pulse = 1'b0;
      base_addr   = {$urandom, $urandom};
      mb_total    = 16'($urandom);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      bit ok;
      for (int k = 0; k < lim && model_active; k++) @(posedge clk);
      ok = !model_active;
      chk("frame_complete", ok, 1);
      if (!ok) pulse_reset();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int a0, b0;
      logic [63:0] b;
      rst         = 1'b1;
      start_pulse = 1'b0;
      base_addr   = '0;
      mb_total    = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Parameter block only
      start_frame(64'h1000, 16'd0);
      wait_idle(200);

      // Three macroblocks: 1 + 3*3 beats
      b0 = beat_total;
      start_frame(64'h0, 16'd3);
      wait_idle(200);
      chk("beats_mb3", 64'(beat_total - b0), 10);

      // Credit limit with read data withheld, then a single retirement
      r_limit = beat_total;
      a0 = ar_total;
      start_frame(64'h2_0000, 16'd8);
      repeat (12) @(posedge clk);
      #2;
      chk("credit_ar_count", 64'(ar_total - a0), 4);
      chk("credit_arvalid", m_axi_arvalid, 0);
      chk("credit_outstanding", outstanding, 4);
      r_limit = beat_total + 1;
      repeat (12) @(posedge clk);
      #2;
      chk("credit_ar_after_rlast", 64'(ar_total - a0), 5);
      chk("credit_arvalid_after", m_axi_arvalid, 0);
      r_limit = -1;
      wait_idle(400);

      // Address stalls in PARAM and in MB
      ar_pct = 0;
      start_frame(64'h3_0080, 16'd3);
      repeat (5) @(posedge clk);
      #2;
      chk("stall_param_arvalid", m_axi_arvalid, 1);
      ar_pct = 100;
      repeat (2) @(posedge clk);
      ar_pct = 0;
      repeat (5) @(posedge clk);
      #2;
      chk("stall_mb_arvalid", m_axi_arvalid, 1);
      ar_pct = 100;
      wait_idle(400);

      // Restart attempt while busy must be ignored
      rv_pct = 60;
      rr_pct = 60;
      start_frame(64'h4_0000, 16'd5);
      repeat (3) @(posedge clk);
      start_frame(64'h9990_0000, 16'd40);
      wait_idle(800);

      // Reset mid-frame with two bursts outstanding
      rv_pct = 100;
      rr_pct = 100;
      r_limit = beat_total;
      start_frame(64'h5_0000, 16'd10);
      for (int k = 0; k < 50 && outstanding != 4'd2; k++) begin
         @(posedge clk);
         #2;
      end
      chk("pre_reset_outstanding", outstanding, 2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      r_limit = -1;
      @(posedge clk);
      start_frame(64'h6_0000, 16'd6);
      wait_idle(400);

      // Randomized frames, including a wrapping base and stray rlast beats while idle
      for (int f = 0; f < 16; f++) begin
         ar_pct = 30 + int'($urandom_range(70));
         rv_pct = 30 + int'($urandom_range(70));
         rr_pct = 30 + int'($urandom_range(70));
         if ($urandom_range(3) == 0) begin
            stray_id++;
            repeat (3) @(posedge clk);
         end
         b = {$urandom, $urandom} & ~64'h7F;
         if (f == 5) b = 64'hFFFF_FFFF_FFFF_FF00;
         start_frame(b, 16'($urandom_range(12)));
         wait_idle(3000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
